// File: rtl/video_arb_pkg.sv
// video_arb_pkg
//   Shared definitions for the video/paint frame-buffer write arbiter:
//   the arbiter state encoding, default bus widths and the width of the
//   video run counter that bounds how long paint can be held off.
package video_arb_pkg;

    // Arbiter state: nobody granted, video DMA granted, paint engine granted.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_VID = 2'd1,
        GNT_PNT = 2'd2
    } arb_state_e;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    // Width of the consecutive-video-completion counter (limit 1..255 fits).
    localparam int RUN_CNT_W = 8;

endpackage : video_arb_pkg

// File: rtl/video_write_arbiter_if.sv
// video_write_arbiter_if
//   Bundles the three Avalon-MM write ports around the arbiter plus the
//   forced-grant status pulse.
//     vid_*  : video DMA master side (address, write, writedata in; waitrequest out)
//     pnt_*  : paint engine master side (same shape as vid_*)
//     mem_*  : downstream memory port (address, write, writedata out; waitrequest in)
//     stat_forced : one-cycle pulse when paint is granted by the run limit
//   Modports:
//     slave  : the arbiter's view (it is the slave of both write masters)
//     master : the environment's view (masters and memory model)
//
//   Handshake: Avalon-MM write. A master holds write/address/writedata
//   stable while its waitrequest is high; a transfer completes in any cycle
//   where write=1 and waitrequest=0.
interface video_write_arbiter_if #(
    parameter int ADDR_W = video_arb_pkg::DEF_ADDR_W,
    parameter int DATA_W = video_arb_pkg::DEF_DATA_W
);

    logic [ADDR_W-1:0] vid_address;
    logic              vid_write;
    logic [DATA_W-1:0] vid_writedata;
    logic              vid_waitrequest;

    logic [ADDR_W-1:0] pnt_address;
    logic              pnt_write;
    logic [DATA_W-1:0] pnt_writedata;
    logic              pnt_waitrequest;

    logic [ADDR_W-1:0] mem_address;
    logic              mem_write;
    logic [DATA_W-1:0] mem_writedata;
    logic              mem_waitrequest;

    logic              stat_forced;

    modport slave (
        input  vid_address, vid_write, vid_writedata,
        output vid_waitrequest,
        input  pnt_address, pnt_write, pnt_writedata,
        output pnt_waitrequest,
        output mem_address, mem_write, mem_writedata,
        input  mem_waitrequest,
        output stat_forced
    );

    modport master (
        output vid_address, vid_write, vid_writedata,
        input  vid_waitrequest,
        output pnt_address, pnt_write, pnt_writedata,
        input  pnt_waitrequest,
        input  mem_address, mem_write, mem_writedata,
        output mem_waitrequest,
        input  stat_forced
    );

endinterface : video_write_arbiter_if

// File: rtl/video_write_arbiter.sv
// video_write_arbiter
//   Shares one Avalon-MM write port into frame-buffer memory between the
//   video DMA (priority) and the paint engine. A run counter bounds the
//   number of consecutive video completions while paint is waiting; when
//   it reaches MAX_VIDEO_RUN the next grant goes to paint.
//
//   Ports:
//     clk_clk       : system clock, rising edge
//     reset_reset_n : asynchronous active-low reset
//     bus           : video_write_arbiter_if.slave (vid_*, pnt_*, mem_*, stat_forced)
//     dbg_state     : current arbiter state
//     dbg_run_cnt   : current consecutive-video-completion count
module video_write_arbiter
    import video_arb_pkg::*;
#(
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int DATA_W        = DEF_DATA_W,
    parameter int MAX_VIDEO_RUN = 16
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset_n,
    video_write_arbiter_if.slave  bus,
    output arb_state_e            dbg_state,
    output logic [RUN_CNT_W-1:0]  dbg_run_cnt
);

    localparam logic [RUN_CNT_W-1:0] MAX_RUN = RUN_CNT_W'(MAX_VIDEO_RUN);

    arb_state_e           state_q, state_d;
    logic [RUN_CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic                 stat_forced_q, stat_forced_d;

    logic [ADDR_W-1:0]    mem_address_c;
    logic [DATA_W-1:0]    mem_writedata_c;
    logic                 mem_write_c;
    logic                 vid_waitrequest_c;
    logic                 pnt_waitrequest_c;

    logic                 completion;
    logic                 vid_done;
    logic                 pnt_done;
    logic                 arbitrate;
    logic                 forced;

    // Output mux: the granted master is passed straight through so a grant
    // taken on a completion edge drives memory in the very next cycle.
    always_comb begin
        mem_address_c     = '0;
        mem_writedata_c   = '0;
        mem_write_c       = 1'b0;
        vid_waitrequest_c = 1'b1;
        pnt_waitrequest_c = 1'b1;
        case (state_q)
            GNT_VID: begin
                mem_address_c     = bus.vid_address;
                mem_writedata_c   = bus.vid_writedata;
                mem_write_c       = bus.vid_write;
                vid_waitrequest_c = bus.mem_waitrequest;
            end
            GNT_PNT: begin
                mem_address_c     = bus.pnt_address;
                mem_writedata_c   = bus.pnt_writedata;
                mem_write_c       = bus.pnt_write;
                pnt_waitrequest_c = bus.mem_waitrequest;
            end
            default: ;
        endcase
    end

    // Next-state, run counter and forced-grant decision.
    always_comb begin
        completion = mem_write_c && !bus.mem_waitrequest;
        vid_done   = completion && (state_q == GNT_VID);
        pnt_done   = completion && (state_q == GNT_PNT);

        // The counter only means something while paint is waiting.
        if (!bus.pnt_write || pnt_done) begin
            run_cnt_d = '0;
        end else if (vid_done && (run_cnt_q != MAX_RUN)) begin
            run_cnt_d = run_cnt_q + 1'b1;
        end else begin
            run_cnt_d = run_cnt_q;
        end

        // Re-arbitration never happens mid-transfer: only from IDLE or on
        // the completing cycle. The limit test uses the count including the
        // completion happening now, so exactly MAX_VIDEO_RUN video
        // completions precede the forced paint grant.
        arbitrate = (state_q == IDLE) || completion;
        forced    = arbitrate && bus.pnt_write && (run_cnt_d == MAX_RUN);

        state_d       = state_q;
        stat_forced_d = 1'b0;
        if (arbitrate) begin
            if (forced) begin
                state_d       = GNT_PNT;
                stat_forced_d = 1'b1;
            end else if (bus.vid_write) begin
                state_d = GNT_VID;
            end else if (bus.pnt_write) begin
                state_d = GNT_PNT;
            end else begin
                state_d = IDLE;
            end
        end else if (((state_q == GNT_VID) && !bus.vid_write) ||
                     ((state_q == GNT_PNT) && !bus.pnt_write)) begin
            // Granted master withdrew without completing: release the port.
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q       <= IDLE;
            run_cnt_q     <= '0;
            stat_forced_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            run_cnt_q     <= run_cnt_d;
            stat_forced_q <= stat_forced_d;
        end
    end

    assign bus.mem_address     = mem_address_c;
    assign bus.mem_writedata   = mem_writedata_c;
    assign bus.mem_write       = mem_write_c;
    assign bus.vid_waitrequest = vid_waitrequest_c;
    assign bus.pnt_waitrequest = pnt_waitrequest_c;
    assign bus.stat_forced     = stat_forced_q;

    assign dbg_state   = state_q;
    assign dbg_run_cnt = run_cnt_q;

endmodule : video_write_arbiter
